// File: rtl/rr_arbiter8.sv
// rr_arbiter8 -- eight-requester round-robin arbiter feeding the 8-to-3 encoder.
//
// A grant is held until the owner asserts done. The next search starts one
// past the last granted index, so the previous owner is always considered
// last. gnt is registered one-hot (or zero) so the downstream combinational
// encoder sees a glitch-free input.
//
// Optional watchdog: define RR_ARBITER8_TIMEOUT_EN to force release of a
// grant held for HOLD_MAX cycles without done. In that case timeout pulses
// for one cycle. Without the macro there is no counter and timeout is tied 0.
//
// Parameters:
//   HOLD_MAX  maximum grant hold time in cycles (watchdog only), 2..255
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   req      request vector, bit n = requester n
//   done     owner releases its grant (ignored in IDLE)
//   gnt      registered one-hot grant (or 0), drives encoder.i
//   busy     OR of gnt, high while a grant is held
//   timeout  one-cycle pulse after a watchdog release
module rr_arbiter8 #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state, state_nx;
    logic [2:0] ptr, ptr_nx;
    logic [7:0] gnt_nx;
    logic       hit;
    logic [2:0] win;
    logic       release_now;

    // An out-of-range HOLD_MAX leaves this marker scope in the elaborated
    // hierarchy, where it is easy to spot.
    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_illegal_hold_max
    end

    // Rotating search: ptr+1 first, ptr itself last. The 3-bit sum wraps
    // modulo 8 for free.
    always_comb begin : search
        hit = 1'b0;
        win = ptr;
        for (int i = 1; i <= 8; i++) begin
            if (!hit && req[ptr + 3'(i)]) begin
                hit = 1'b1;
                win = ptr + 3'(i);
            end
        end
    end

`ifdef RR_ARBITER8_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    logic [7:0] hold_cnt, hold_cnt_nx;
    logic       wd_fire;
    logic       timeout_nx;

    assign wd_fire     = (state == GRANT) && (hold_cnt == HOLD_LAST);
    assign release_now = done | wd_fire;
    // A done on the watchdog edge is an ordinary release.
    assign timeout_nx  = wd_fire & ~done;

    // Count only while a grant is being held. Any release, new grant or
    // idle cycle restarts the count from zero.
    always_comb begin
        hold_cnt_nx = 8'd0;
        if (state == GRANT && !release_now)
            hold_cnt_nx = hold_cnt + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= 8'd0;
            timeout  <= 1'b0;
        end else begin
            hold_cnt <= hold_cnt_nx;
            timeout  <= timeout_nx;
        end
    end
`else
    assign release_now = done;
    assign timeout     = 1'b0;
`endif

    always_comb begin : fsm_next
        state_nx = state;
        gnt_nx   = gnt;
        ptr_nx   = ptr;
        case (state)
            IDLE: begin
                if (hit) begin
                    gnt_nx   = 8'b1 << win;
                    ptr_nx   = win;
                    state_nx = GRANT;
                end
            end
            GRANT: begin
                // req changes are ignored until release. On release, the
                // same-cycle req is searched, so handoff needs no idle cycle.
                if (release_now) begin
                    if (hit) begin
                        gnt_nx = 8'b1 << win;
                        ptr_nx = win;
                    end else begin
                        gnt_nx   = 8'd0;
                        state_nx = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin : fsm_reg
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= 8'd0;
            ptr   <= 3'd7;
        end else begin
            state <= state_nx;
            gnt   <= gnt_nx;
            ptr   <= ptr_nx;
        end
    end

    assign busy = |gnt;

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

- Eight-requester round-robin arbiter that sits directly upstream of the 8-to-3 `encoder`.
- Its registered one-hot `gnt[7:0]` drives the encoder's `i[7:0]`, so the encoder's `d[2:0]` is always the index of the current grant holder.
- A grant is held until the owner signals `done`; fairness comes from a rotating priority pointer.
- A compile-time watchdog can force release of a grant that is held too long.

## Interface
Parameters:
- `HOLD_MAX`, default 16: maximum cycles a grant may be held before forced release. Used only with the watchdog. Legal range 2..255.

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `req`  input  8  request vector; bit n = requester n.
- `done`  input  1  current owner releases its grant; sampled only in GRANT.
- `gnt`  output  8  registered grant. All-zero or exactly one bit set. Connects to `encoder.i`.
- `busy`  output  1  high while in GRANT; equals OR of `gnt`.
- `timeout`  output  1  one-cycle pulse on forced release (watchdog only).

## Operation
- Two-state FSM: IDLE, GRANT.
- Priority pointer `ptr[2:0]` holds the index of the last granted requester.
- Search order is `ptr+1`, `ptr+2`, … `ptr+8`, wrapping modulo 8; the first set `req` bit wins.
- IDLE:
  - If `req` is nonzero: set the winner's bit in `gnt`, set `ptr` to the winner index, go to GRANT.
  - Else stay in IDLE with `gnt`=0.
- GRANT:
  - `gnt` is held constant regardless of `req` changes, including the owner dropping its request.
  - On `done`=1: search again, with the updated `ptr`, over the `req` sampled in that same cycle.
    - If a winner exists, `gnt` moves to it on the next edge (back-to-back handoff, no idle cycle) and the FSM stays in GRANT.
    - Else `gnt` goes to 0 and the FSM goes to IDLE.
  - The owner may re-win only if no other requester is pending, because it is searched last.
- `done` in IDLE is ignored.

## Timing
- Reset (`rst_n`=0, asynchronous): `gnt`=0, `busy`=0, `timeout`=0, FSM=IDLE, `ptr`=7 (so the first search starts at requester 0), hold counter=0.
- Reset deassertion mid-grant: no grant survives; arbitration restarts from requester 0.
- Latency:
  - `req` seen at edge k in IDLE produces `gnt` valid after edge k.
  - `done` at edge k produces the new `gnt` (or 0) after edge k.
- Outputs are registered, so `gnt` is glitch-free into the combinational encoder. `d` is valid the same cycle as `gnt`.
- `done` and a new `req` rising in the same cycle: the new `req` takes part in that search.
- `req`=8'hFF continuously with `done` every cycle: grants rotate 0,1,2,…,7,0.

## Configuration
- Macro: `RR_ARBITER8_TIMEOUT_EN`.
- Defined:
  - An 8-bit hold counter clears on every new grant and increments each GRANT cycle without `done`.
  - When the counter reaches `HOLD_MAX-1` without `done`, the next edge performs the same release/handoff as `done`, and `timeout` is 1 for exactly that one following cycle.
  - `done` coincident with the timeout edge is a normal release and does not pulse `timeout`.
- Not defined:
  - No counter logic exists.
  - `timeout` is tied 0.
  - A grant is held indefinitely until `done`.

## Test plan
- Reset behaviour: assert `rst_n`=0 mid-grant with `gnt`=8'h10 → `gnt`=0 and `busy`=0 immediately (asynchronous). Release reset with `req`=8'hFF → `gnt`=8'h01, encoder `d`=3'd0.
- Single requester: `req`=8'h20 in IDLE → `gnt`=8'h20 one edge later, `d`=3'd5. Pulse `done` → `gnt`=0, `busy`=0.
- Round-robin fairness: `req`=8'h81 held, `done` pulsed each grant → `gnt` alternates 8'h01, 8'h80, 8'h01, ….
- Back-to-back handoff: owner 2 holding, `req`=8'h0C, `done`=1 → `gnt` goes from 8'h04 to 8'h08 with no zero cycle.
- Hold independent of `req`: owner 3 holding, drop `req`[3] and raise `req`[6] → `gnt` stays 8'h08 until `done`.
- Watchdog (with `RR_ARBITER8_TIMEOUT_EN`, `HOLD_MAX`=4): grant to 1 with no `done`, `req`=8'h12 → after 4 GRANT cycles `gnt`=8'h10 and `timeout` is high for exactly 1 cycle. Without the macro: `gnt` stays 8'h02 and `timeout`=0.
